pll_lock_sequencer: RTL
=======================

Name: pll_lock_sequencer

Overview:
- Power-up and supervision controller for the GW5A PLLA clock generator (50 MHz clkin to CLKOUT0).
- Sequences PLLPWD and RESET, waits for a qualified LOCK, then releases the system reset for the fabric clocked from clkout0.
- Runs entirely on clkin, so it keeps working while the PLL is unlocked.
- Detects loss of lock, retries a bounded number of times, then latches a fault.

Parameters:
- PWD_CYCLES, 16, clkin cycles PLL is held powered down (pll_pwd=1).
- RST_CYCLES, 64, clkin cycles PLL reset is asserted after power-up.
- LOCK_TIMEOUT, 50000, max clkin cycles to wait for lock after reset release (1 ms at 50 MHz).
- STABLE_CYCLES, 1024, consecutive synchronized-lock-high cycles required before release.
- MAX_RETRIES, 3, lock attempts allowed after the first before FAULT.
- CNT_W, 20, timer width; elaboration check that it holds max(PWD,RST,TIMEOUT,STABLE)-1.

Ports:
- clkin  input  1  reference clock (50 MHz); sole clock of the block.
- reset  input  1  asynchronous, active-high reset.
- pll_lock  input  1  PLLA LOCK, asynchronous to clkin; 2-FF synchronized internally.
- relock_req  input  1  single-cycle pulse requesting a full re-sequence; also clears FAULT.
- pll_pwd  output  1  to PLLA PLLPWD.
- pll_reset  output  1  to PLLA RESET.
- sys_reset  output  1  active-high reset for downstream logic; the consumer synchronizes it into the clkout0 domain.
- ready  output  1  high only in RUN.
- fault  output  1  high only in FAULT.
- retry_cnt  output  2  failed attempts in the current sequence, saturating at 3.
- state_dbg  output  3  encoded current state.

Behaviour:
- Reset values while reset=1:
  - State PWRDN, timer=0, retry_cnt=0.
  - pll_pwd=1, pll_reset=1, sys_reset=1, ready=0, fault=0.
  - Both lock synchronizer flops = 0.
- lock_s: the 2nd synchronizer stage; 2-cycle latency from pll_lock.
- All outputs are registered and decoded from the next state, so they change on the same edge as the state.
- sys_reset=1 in every state except RUN.
- State encoding: PWRDN=0, PLLRST=1, WAIT_LOCK=2, STABLE=3, RUN=4, FAULT=5.
- PWRDN:
  - pll_pwd=1, pll_reset=1.
  - When timer reaches PWD_CYCLES-1, go to PLLRST with timer cleared.
- PLLRST:
  - pll_pwd=0, pll_reset=1.
  - When timer reaches RST_CYCLES-1, go to WAIT_LOCK with timer cleared.
- WAIT_LOCK:
  - pll_pwd=0, pll_reset=0.
  - If lock_s=1, go to STABLE with timer cleared.
  - Else, if timer reaches LOCK_TIMEOUT-1, a failed attempt occurs.
- STABLE:
  - If lock_s=0, a failed attempt occurs (glitch during qualification).
  - Else, if timer reaches STABLE_CYCLES-1, go to RUN.
- Failed attempt:
  - If retry_cnt < MAX_RETRIES: increment retry_cnt and go to PLLRST.
  - Otherwise: go to FAULT.
- RUN:
  - ready=1, sys_reset=0, retry_cnt is held.
  - If lock_s falls, go to PLLRST with sys_reset=1 on the same edge. This counts as a failed attempt only for the purpose of incrementing retry_cnt.
- FAULT:
  - pll_pwd=1, pll_reset=1, fault=1.
  - Stays until reset or relock_req.
- relock_req:
  - In any state, go to PWRDN, clear retry_cnt and timer. This has priority over all other transitions on the same edge.
  - While already in PWRDN, it restarts the PWD timer.
- Timer:
  - Counts up by 1 per cycle and clears on every state change.
  - Never wraps: each state exits on its terminal count before the maximum value.
- retry_cnt saturates at 3 and never wraps.
- Asserting reset mid-sequence returns everything to the reset values immediately (asynchronous). The sequence restarts from PWRDN on the first clkin edge after release.

Decomposition:
- Shared package pll_seq_pkg holds:
  - the state enum and its 3-bit encoding (shared with the debug/status register block);
  - default timing constants for 50 MHz.
- One sub-module, sync_2ff: a generic 2-flop synchronizer with async active-high reset to 0. It is reused elsewhere for the lock synchronizer.

Test Plan (bench overrides parameters: PWD=4, RST=8, TIMEOUT=100, STABLE=16, MAX_RETRIES=2):
- Nominal lock:
  - Stimulus: release reset, raise pll_lock 20 cycles after pll_reset falls, hold it high.
  - Required: pll_pwd falls at cycle 4, pll_reset falls at cycle 12; sys_reset falls and ready rises 16+2 cycles after pll_lock rises; retry_cnt=0.
- No lock:
  - Stimulus: pll_lock held at 0.
  - Required: three 100-cycle WAIT_LOCK windows, each separated by an 8-cycle PLLRST; retry_cnt 0→1→2; then FAULT, with fault=1, pll_pwd=1, sys_reset=1.
- Qualification glitch:
  - Stimulus: lock high for 10 cycles, low for 1 cycle, then high.
  - Required: return to PLLRST, retry_cnt=1, sys_reset never deasserts during the glitch; RUN is reached after the second qualification.
- Loss of lock in RUN:
  - Stimulus: drop pll_lock for 3 cycles.
  - Required: sys_reset=1 and ready=0 exactly 2 cycles after the fall (synchronizer latency); state_dbg=1; retry_cnt increments.
- Relock from FAULT:
  - Stimulus: pulse relock_req while in FAULT.
  - Required: state PWRDN next cycle, fault=0, retry_cnt=0, full sequence reruns.
- Async reset mid-STABLE:
  - Stimulus: assert reset between clkin edges.
  - Required: outputs take their reset values without waiting for a clock edge; restart from PWRDN after release.

Source files
------------

// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: shared state encoding and default 50 MHz timing for the PLL lock sequencer
package pll_seq_pkg;
  typedef enum logic [2:0] {
    PWRDN     = 3'd0,
    PLLRST    = 3'd1,
    WAIT_LOCK = 3'd2,
    STABLE    = 3'd3,
    RUN       = 3'd4,
    FAULT     = 3'd5
  } state_t;
  localparam int PWD_CYCLES_DEF    = 16;
  localparam int RST_CYCLES_DEF    = 64;
  localparam int LOCK_TIMEOUT_DEF  = 50000;
  localparam int STABLE_CYCLES_DEF = 1024;
  localparam int MAX_RETRIES_DEF   = 3;
  localparam int CNT_W_DEF         = 20;
  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a > b ? a : b;
    m = m > c ? m : c;
    return m > d ? m : d;
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer with asynchronous active-high reset to 0
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;
  // shift the asynchronous input through two flops to settle metastability
  always_ff @(posedge clk or posedge rst)
    if (rst) {q, meta} <= 2'b00;
    else     {q, meta} <= {meta, d};
endmodule

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: powers up a PLL, qualifies lock, releases system reset and supervises lock loss
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int PWD_CYCLES    = PWD_CYCLES_DEF,
  parameter int RST_CYCLES    = RST_CYCLES_DEF,
  parameter int LOCK_TIMEOUT  = LOCK_TIMEOUT_DEF,
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int MAX_RETRIES   = MAX_RETRIES_DEF,
  parameter int CNT_W         = CNT_W_DEF
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       pll_lock,
  input  logic       relock_req,
  output logic       pll_pwd,
  output logic       pll_reset,
  output logic       sys_reset,
  output logic       ready,
  output logic       fault,
  output logic [1:0] retry_cnt,
  output logic [2:0] state_dbg
);
  localparam int MAX_T = max4(PWD_CYCLES, RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  if (((MAX_T - 1) >> CNT_W) != 0) begin : g_cnt_w_check
    $error("CNT_W too narrow for the longest timing parameter");
  end
  state_t           state, nxt;
  logic [CNT_W-1:0] timer;
  logic [1:0]       retry_nxt;
  logic             lock_s, fail, can_retry;
  sync_2ff u_lock_sync (
    .clk (clkin),
    .rst (reset),
    .d   (pll_lock),
    .q   (lock_s)
  );
  assign state_dbg = state;
  assign can_retry = 32'(retry_cnt) < MAX_RETRIES;
  // next-state and retry bookkeeping; relock_req overrides everything
  always_comb begin
    nxt       = state;
    fail      = 1'b0;
    retry_nxt = retry_cnt;
    case (state)
      PWRDN:     nxt = timer == CNT_W'(PWD_CYCLES - 1) ? PLLRST : PWRDN;
      PLLRST:    nxt = timer == CNT_W'(RST_CYCLES - 1) ? WAIT_LOCK : PLLRST;
      WAIT_LOCK: begin
        nxt  = lock_s ? STABLE : WAIT_LOCK;
        fail = !lock_s && timer == CNT_W'(LOCK_TIMEOUT - 1);
      end
      STABLE: begin
        nxt  = timer == CNT_W'(STABLE_CYCLES - 1) ? RUN : STABLE;
        fail = !lock_s;
      end
      RUN: begin
        nxt       = lock_s ? RUN : PLLRST;
        retry_nxt = lock_s || &retry_cnt ? retry_cnt : retry_cnt + 2'd1;
      end
      default:   nxt = FAULT;
    endcase
    if (fail) begin
      nxt       = can_retry ? PLLRST : FAULT;
      retry_nxt = can_retry && !(&retry_cnt) ? retry_cnt + 2'd1 : retry_cnt;
    end
    if (relock_req) begin
      nxt       = PWRDN;
      retry_nxt = '0;
    end
  end
  // state, timer and outputs all registered, outputs decoded from the next state
  always_ff @(posedge clkin or posedge reset)
    if (reset) begin
      state     <= PWRDN;
      timer     <= '0;
      retry_cnt <= '0;
      pll_pwd   <= 1'b1;
      pll_reset <= 1'b1;
      sys_reset <= 1'b1;
      ready     <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state     <= nxt;
      retry_cnt <= retry_nxt;
      timer     <= (nxt != state || relock_req || nxt inside {RUN, FAULT}) ? '0 : timer + 1'b1;
      pll_pwd   <= nxt inside {PWRDN, FAULT};
      pll_reset <= nxt inside {PWRDN, PLLRST, FAULT};
      sys_reset <= nxt != RUN;
      ready     <= nxt == RUN;
      fault     <= nxt == FAULT;
    end
endmodule
